// File: rtl/iob_wb_pkg.sv
// Shared constants for the IOb-to-Wishbone bridge:
// FSM state codes, termination causes, byte-lane helper.
package iob_wb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] TERM_ACK  = 2'd0;
  localparam logic [1:0] TERM_ERR  = 2'd1;
  localparam logic [1:0] TERM_TMO  = 2'd2;
  localparam logic [1:0] TERM_NONE = 2'd3;

  // WB_SEL_W: one select bit per data byte
  function automatic int wb_sel_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_iob2wishbone_if.sv
// Bus bundle of the bridge: IOb request/response + Wishbone master.
// slave = bridge view, master = core/peripheral side view.
interface iob_iob2wishbone_if
  import iob_wb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  localparam int SEL_W = wb_sel_w(DATA_W);

  logic              valid_i;
  logic [ADDR_W-1:0] address_i;
  logic [DATA_W-1:0] wdata_i;
  logic [SEL_W-1:0]  wstrb_i;
  logic [DATA_W-1:0] rdata_o;
  logic              ready_o;
  logic              err_o;

  logic [ADDR_W-1:0] wb_addr_o;
  logic [SEL_W-1:0]  wb_select_o;
  logic              wb_we_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [DATA_W-1:0] wb_data_i;
  logic              wb_ack_i;
  logic              wb_error_i;

  modport slave (
    input  valid_i, address_i, wdata_i, wstrb_i,
    input  wb_data_i, wb_ack_i, wb_error_i,
    output rdata_o, ready_o, err_o,
    output wb_addr_o, wb_select_o, wb_we_o,
    output wb_cyc_o, wb_stb_o, wb_data_o
  );

  modport master (
    output valid_i, address_i, wdata_i, wstrb_i,
    output wb_data_i, wb_ack_i, wb_error_i,
    input  rdata_o, ready_o, err_o,
    input  wb_addr_o, wb_select_o, wb_we_o,
    input  wb_cyc_o, wb_stb_o, wb_data_o
  );

endinterface

// File: rtl/iob_wb_timer.sv
// Bus-cycle watchdog: counts enabled cycles, tc_o in the TIMEOUT-th.
// Ports: clk_i, arst_i, clr_i (sync clear), en_i, tc_o. TIMEOUT=0 disables.
module iob_wb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_ok;
    assign unused_ok = ^{clk_i, arst_i, clr_i, en_i};
    assign tc_o = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // cnt_q counts completed cycles, so LAST marks the final one
    assign tc_o = en_i & (cnt_q == LAST);
  end

endmodule

// File: rtl/iob_iob2wishbone.sv
// IOb slave -> Wishbone classic master, one transaction at a time.
// Ports: clk_i, arst_i (async, active-high), bus (slave modport).
module iob_iob2wishbone
  import iob_wb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               arst_i,
  iob_iob2wishbone_if.slave  bus
);

  localparam int SEL_W = wb_sel_w(DATA_W);
  localparam logic [ADDR_W-1:0] LANE_M =
    ADDR_W'(SEL_W - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        term;
  logic              in_bus;
  logic              tmo;

  assign in_bus = (state_q == ST_BUS);

  iob_wb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .clr_i  (~in_bus),
    .en_i   (in_bus),
    .tc_o   (tmo)
  );

  // error beats ack beats timeout
  always_comb begin
    term = TERM_NONE;
    if (bus.wb_error_i) begin
      term = TERM_ERR;
    end else if (bus.wb_ack_i) begin
      term = TERM_ACK;
    end else if (tmo) begin
      term = TERM_TMO;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (bus.valid_i) begin
          addr_d  = bus.address_i & ~LANE_M;
          wdat_d  = bus.wdata_i;
          we_d    = |bus.wstrb_i;
          sel_d   = (|bus.wstrb_i) ? bus.wstrb_i : '1;
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end
      end
      (state_q == ST_BUS): begin
        if (term != TERM_NONE) begin
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          err_d   = (term != TERM_ACK);
          if (!we_q) begin
            rdata_d = (term == TERM_ACK) ?
                      bus.wb_data_i : '1;
          end
          state_d = ST_RESP;
        end
      end
      (state_q == ST_RESP): begin
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.wb_addr_o   = addr_q;
  assign bus.wb_data_o   = wdat_q;
  assign bus.wb_select_o = sel_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.ready_o     = ready_q;
  assign bus.err_o       = err_q;
  assign bus.rdata_o     = rdata_q;

endmodule

// File: tb/tb_iob_iob2wishbone.sv
// Directed bench for iob_iob2wishbone with a transaction-timing model
// and a per-cycle compare process.
module tb_iob_iob2wishbone;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  iob_iob2wishbone_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  iob_iob2wishbone #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bif)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int n_cyc_hi = 0;
  int rq[$];
  int last_req;
  bit chk_on = 1'b0;
  bit stale = 1'b0;

  logic        e_cyc, e_we, e_ready, e_err;
  logic [3:0]  e_sel;
  logic [31:0] e_addr, e_wdat, e_rdata;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc", 32'(bif.wb_cyc_o), 32'(e_cyc));
      chk("stb", 32'(bif.wb_stb_o), 32'(e_cyc));
      chk("ready", 32'(bif.ready_o), 32'(e_ready));
      if (e_cyc) begin
        chk("wb_addr", bif.wb_addr_o, e_addr);
        chk("wb_sel", 32'(bif.wb_select_o), 32'(e_sel));
        chk("wb_we", 32'(bif.wb_we_o), 32'(e_we));
        if (e_we) chk("wb_data", bif.wb_data_o, e_wdat);
      end
      if (e_ready) begin
        chk("err", 32'(bif.err_o), 32'(e_err));
        chk("rdata", bif.rdata_o, e_rdata);
      end
      if (bif.wb_cyc_o) n_cyc_hi++;
      if (bif.ready_o) rq.push_back(cyc_n);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bif.valid_i = 1'b0;
      bif.wb_ack_i = 1'b0;
      bif.wb_error_i = 1'b0;
      e_cyc = 1'b0;
      e_ready = 1'b0;
    end
  endtask

  // kind: 0 ack, 1 err, 2 err+ack, 3 silent (timeout)
  task automatic xact(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input int waits,
                      input int kind, input logic [31:0] rd,
                      input bit drop_v);
    int nb;
    bit we;
    nb = (kind == 3) ? 8 : waits + 1;
    we = (ws != 4'h0);
    tick();
    bif.valid_i = 1'b1;
    bif.address_i = a;
    bif.wdata_i = wd;
    bif.wstrb_i = ws;
    bif.wb_ack_i = stale;
    bif.wb_error_i = 1'b0;
    bif.wb_data_i = ~rd;
    e_cyc = 1'b0;
    e_ready = 1'b0;
    last_req = cyc_n;
    for (int i = 0; i < nb; i++) begin
      tick();
      if (drop_v) bif.valid_i = 1'b0;
      e_cyc = 1'b1;
      e_addr = a & ~32'h3;
      e_sel = we ? ws : 4'hF;
      e_we = we;
      e_wdat = wd;
      if (i == nb - 1 && kind != 3) begin
        bif.wb_ack_i = stale | (kind == 0) | (kind == 2);
        bif.wb_error_i = (kind == 1) | (kind == 2);
        bif.wb_data_i = rd;
      end else begin
        bif.wb_ack_i = stale;
        bif.wb_error_i = 1'b0;
        bif.wb_data_i = ~rd;
      end
    end
    tick();
    bif.wb_ack_i = stale;
    bif.wb_error_i = 1'b0;
    bif.wb_data_i = ~rd;
    e_cyc = 1'b0;
    e_ready = 1'b1;
    e_err = (kind != 0);
    e_rdata = we ? 32'h0 : ((kind == 0) ? rd : 32'hFFFF_FFFF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int h0;
    arst = 1'b1;
    bif.valid_i = 1'b0;
    bif.address_i = '0;
    bif.wdata_i = '0;
    bif.wstrb_i = '0;
    bif.wb_data_i = '0;
    bif.wb_ack_i = 1'b0;
    bif.wb_error_i = 1'b0;
    e_cyc = 0; e_we = 0; e_ready = 0; e_err = 0;
    e_sel = 0; e_addr = 0; e_wdat = 0; e_rdata = 0;
    #2;
    chk("rst_ready", 32'(bif.ready_o), 32'h0);
    chk("rst_err", 32'(bif.err_o), 32'h0);
    chk("rst_rdata", bif.rdata_o, 32'h0);
    chk("rst_cyc", 32'(bif.wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(bif.wb_stb_o), 32'h0);
    chk("rst_we", 32'(bif.wb_we_o), 32'h0);
    chk("rst_sel", 32'(bif.wb_select_o), 32'h0);
    chk("rst_addr", bif.wb_addr_o, 32'h0);
    chk("rst_wdata", bif.wb_data_o, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 arst = 1'b0;
    chk_on = 1'b1;
    idle(1);

    // read, zero wait states
    r0 = rq.size();
    xact(32'h47, 32'h0, 4'h0, 0, 0, 32'hCAFE_F00D, 1'b0);
    chk("rd_rdata_lit", bif.rdata_o, 32'hCAFE_F00D);
    chk("rd_err_lit", 32'(bif.err_o), 32'h0);
    chk("rd_addr_lit", bif.wb_addr_o, 32'h44);
    chk("rd_sel_lit", 32'(bif.wb_select_o), 32'hF);
    idle(1);
    chk("rd_latency", 32'(rq[r0] - last_req), 32'd2);

    // write, 3 wait states, valid dropped mid-cycle
    r0 = rq.size();
    xact(32'h10, 32'h1234_5678, 4'h3, 3, 0, 32'h0, 1'b1);
    chk("wr_rdata_lit", bif.rdata_o, 32'h0);
    chk("wr_err_lit", 32'(bif.err_o), 32'h0);
    chk("wr_data_lit", bif.wb_data_o, 32'h1234_5678);
    idle(1);
    chk("wr_latency", 32'(rq[r0] - last_req), 32'd5);

    // read with error and ack together
    xact(32'h84, 32'h0, 4'h0, 0, 2, 32'h1111_2222, 1'b0);
    chk("er_rdata_lit", bif.rdata_o, 32'hFFFF_FFFF);
    chk("er_err_lit", 32'(bif.err_o), 32'h1);
    idle(1);

    // write terminated by error
    xact(32'h8, 32'hA5A5_A5A5, 4'hC, 1, 1, 32'h0, 1'b0);
    chk("we_err_lit", 32'(bif.err_o), 32'h1);
    idle(1);

    // silent slave -> timeout after 8 bus cycles
    h0 = n_cyc_hi;
    xact(32'h30, 32'h0, 4'h0, 0, 3, 32'h0, 1'b0);
    chk("tmo_rdata_lit", bif.rdata_o, 32'hFFFF_FFFF);
    chk("tmo_err_lit", 32'(bif.err_o), 32'h1);
    idle(1);
    chk("tmo_cyc_cycles", 32'(n_cyc_hi - h0), 32'd8);

    // async reset during the bus cycle
    r0 = rq.size();
    tick();
    bif.valid_i = 1'b1;
    bif.address_i = 32'h20;
    bif.wstrb_i = 4'h0;
    tick();
    e_cyc = 1'b1; e_addr = 32'h20; e_sel = 4'hF; e_we = 1'b0;
    tick();
    #1 arst = 1'b1;
    bif.valid_i = 1'b0;
    e_cyc = 1'b0;
    #1;
    chk("arst_cyc_async", 32'(bif.wb_cyc_o), 32'h0);
    chk("arst_stb_async", 32'(bif.wb_stb_o), 32'h0);
    tick();
    tick();
    arst = 1'b0;
    idle(3);
    chk("arst_no_ready", 32'(rq.size() - r0), 32'd0);
    xact(32'h2C, 32'h0, 4'h0, 1, 0, 32'h600D_BEEF, 1'b0);
    chk("arst_rd_lit", bif.rdata_o, 32'h600D_BEEF);
    idle(1);

    // back-to-back with ack stuck high
    stale = 1'b1;
    r0 = rq.size();
    for (int k = 0; k < 4; k++) begin
      xact(32'h100 + 32'(4 * k), 32'h0, 4'h0, 0, 0,
           32'hB0B0_0000 + 32'(k), 1'b0);
    end
    stale = 1'b0;
    idle(3);
    chk("b2b_pulses", 32'(rq.size() - r0), 32'd4);
    for (int k = 0; k < 3; k++) begin
      chk("b2b_spacing", 32'(rq[r0 + k + 1] - rq[r0 + k]), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iob_iob2wishbone.md
# iob_iob2wishbone

IOb-slave to Wishbone-master bridge: accepts single IOb requests from the core-side interconnect and executes each as one Wishbone classic cycle toward a Wishbone peripheral such as the Ethernet MAC register file. It is the counterpart of the Wishbone-to-IOb bridge, so the same MAC can be driven from an IOb master. One transaction is outstanding at a time. Bus errors and timeouts are reported alongside the IOb response.

## Interface
Parameters:
- ADDR_W, 32, byte address width on both sides
- DATA_W, 32, data width; DATA_W/8 byte lanes
- TIMEOUT, 255, cycles to wait for ack/err before forced termination; 0 disables the timeout

Ports (reset arst_i, asynchronous, active-high; clock clk_i):
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- valid_i  in  1  IOb request; held by the master until ready_o
- address_i  in  ADDR_W  IOb byte address
- wdata_i  in  DATA_W  IOb write data
- wstrb_i  in  DATA_W/8  byte strobes; all-zero means read
- rdata_o  out  DATA_W  read data; valid only while ready_o=1
- ready_o  out  1  one-cycle response strobe
- err_o  out  1  high with ready_o when the cycle ended in wb_error_i or timeout
- wb_addr_o  out  ADDR_W  Wishbone address, lane bits forced to 0
- wb_select_o  out  DATA_W/8  byte select
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_data_o  out  DATA_W  write data
- wb_data_i  in  DATA_W  read data
- wb_ack_i  in  1  acknowledge
- wb_error_i  in  1  bus error

## Operation
- FSM states IDLE, BUS, RESP; reset state IDLE.
- IDLE: on valid_i=1, register address (lane bits cleared), wdata, we=|wstrb_i, select=wstrb_i for writes / all ones for reads; go BUS.
- BUS: wb_cyc_o=wb_stb_o=1, all wb_* outputs stable. Timer counts cycles in BUS. Exit on wb_error_i, wb_ack_i, or timer reaching TIMEOUT (TIMEOUT>0): capture termination cause; on ack of a read capture wb_data_i; go RESP.
- Priority on the same cycle: wb_error_i > wb_ack_i > timeout.
- RESP: ready_o=1 for exactly one cycle; rdata_o = captured data (ack), all ones (error/timeout read), 0 for writes; err_o=1 on error/timeout. valid_i ignored in RESP; go IDLE.
- wb_ack_i / wb_error_i outside BUS are ignored.
- valid_i dropped by a misbehaving master while in BUS does not abort the cycle.

## Timing
- All outputs registered; reset values: ready_o=0, err_o=0, rdata_o=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_select_o=0, wb_addr_o=0, wb_data_o=0; timer=0.
- valid_i sampled at edge n -> wb_cyc_o/wb_stb_o high in cycle n+1.
- Ack in cycle n+k (k>=1) -> wb_cyc_o/wb_stb_o low in n+k+1, ready_o high in n+k+1. Minimum request-to-ready latency: 2 cycles; back-to-back throughput: one transaction per 3 cycles.
- Timeout: cyc/stb held TIMEOUT cycles, dropped on the following edge with ready_o/err_o=1.
- New valid_i accepted no earlier than the cycle after ready_o.
- arst_i mid-cycle: wb_cyc_o/wb_stb_o drop immediately (asynchronous), no ready_o issued, FSM IDLE; the master must reissue.

## Structure
- Package iob_wb_pkg: FSM state encoding localparams, termination-cause codes (ACK, ERR, TMO), WB_SEL_W = DATA_W/8.
- Sub-module iob_wb_timer: clear/enable counter with terminal-count flag at TIMEOUT, disabled when TIMEOUT=0.
- Top: FSM, request registers, response registers.

## Test plan
- Read: valid_i, address_i=0x0000_0047, wstrb_i=0; slave acks in 1st BUS cycle with 0xCAFE_F00D -> wb_addr_o=0x44, wb_select_o=0xF, wb_we_o=0; ready_o 2 cycles after request, rdata_o=0xCAFE_F00D, err_o=0.
- Write: address 0x10, wdata 0x1234_5678, wstrb 0x3; ack after 3 wait states -> wb_we_o=1, select 0x3, wb_data_o stable throughout; ready_o 1 cycle after ack, err_o=0.
- Error: read with wb_error_i and wb_ack_i asserted together -> ready_o with err_o=1, rdata_o=0xFFFF_FFFF.
- Timeout: TIMEOUT=8, slave never responds -> cyc/stb high exactly 8 cycles, then ready_o=1, err_o=1, rdata_o=all ones.
- Reset: assert arst_i during BUS -> wb_cyc_o=0 same cycle, no ready_o; after release, a new read completes normally.
- Back-to-back: valid_i held high across 4 requests with zero-wait ack -> 4 ready_o pulses 3 cycles apart, no spurious cycle from a stale acknowledge.
